// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access; data wins ties. Optional MEM_TIMEOUT_EN adds a wait timeout.
// Latency: strobe one cycle after the request is sampled, done one cycle after ready/ack (2 cycles minimum).
// Backpressure: requesters hold req until their done pulse; strobes are held until memory answers (or times out).
module mem_port_arbiter #(
    parameter int WORD_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              readM,
    output logic              writeM,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              inputReady,
    input  logic              ackOutput,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              readm_q, readm_d;
    logic              writem_q, writem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              busy_q, busy_d;
    logic              finish;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       err_q, err_d;
    logic       to_hit;

    assign cnt_inc = cnt_q + 8'd1;
    assign to_hit  = (cnt_inc == TO_LIM);
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        readm_d    = readm_q;
        writem_d   = writem_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        finish     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    if (d_we) begin
                        writem_d = 1'b1;
                        state_d  = WR_WAIT;
                    end else begin
                        readm_d = 1'b1;
                        state_d = RD_WAIT;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                end else if (if_req) begin
                    owner_d = 1'b0;
                    addr_d  = if_addr;
                    readm_d = 1'b1;
                    state_d = RD_WAIT;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                end
            end
            RD_WAIT: begin
                if (inputReady) begin
                    if (owner_q) d_rdata_d  = mem_rdata;
                    else         if_rdata_d = mem_rdata;
                    readm_d = 1'b0;
                    finish  = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (to_hit) begin
                    readm_d = 1'b0;
                    err_d   = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            WR_WAIT: begin
                if (ackOutput) begin
                    writem_d = 1'b0;
                    finish   = 1'b1;
                end
`ifdef MEM_TIMEOUT_EN
                else if (to_hit) begin
                    writem_d = 1'b0;
                    err_d    = 1'b1;
                    finish   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Done is raised on the same edge the FSM enters DONE, so it lasts exactly that one state.
        if (finish) begin
            state_d   = DONE;
            if_done_d = ~owner_q;
            d_done_d  = owner_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            readm_q    <= 1'b0;
            writem_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            readm_q    <= readm_d;
            writem_q   <= writem_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign readM     = readm_q;
    assign writeM    = writem_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign busy      = busy_q;

endmodule
